// File: rtl/debug_dump_sequencer_if.sv
// Pipeline-side and UART-side signals of the post-halt dump sequencer.
// master = the sequencer, slave = its environment (pipeline debug ports, uart_tx, debug_unit).
interface debug_dump_sequencer_if #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int NB_ADDR = 7,
   parameter int N_BITS  = 8
);
   logic               i_start;
   logic [NB_DATA-1:0] i_pc;
   logic [NB_DATA-1:0] i_cycles;
   logic               o_reg_rd;
   logic [NB_REG-1:0]  o_reg_addr;
   logic [NB_DATA-1:0] i_reg_data;
   logic               o_mem_rd;
   logic [NB_ADDR-1:0] o_mem_addr;
   logic [NB_DATA-1:0] i_mem_data;
   logic               i_mem_dirty;
   // o_tx_start is a one-cycle request; o_tx_data stays stable until the i_tx_done pulse.
   logic               o_tx_start;
   logic [N_BITS-1:0]  o_tx_data;
   logic               i_tx_done;
   logic               o_busy;
   logic               o_done;
   logic [3:0]         o_dbg_state;

   modport master (
      input  i_start, i_pc, i_cycles, i_reg_data, i_mem_data, i_mem_dirty, i_tx_done,
      output o_reg_rd, o_reg_addr, o_mem_rd, o_mem_addr, o_tx_start, o_tx_data,
             o_busy, o_done, o_dbg_state
   );

   modport slave (
      output i_start, i_pc, i_cycles, i_reg_data, i_mem_data, i_mem_dirty, i_tx_done,
      input  o_reg_rd, o_reg_addr, o_mem_rd, o_mem_addr, o_tx_start, o_tx_data,
             o_busy, o_done, o_dbg_state
   );
endinterface

// File: rtl/debug_dump_sequencer.sv
// Streams PC, cycle count, registers, dirty memory words and an 0xFF marker to uart_tx.
// Optional macro DUMP_SEQ_CHECKSUM_EN appends an XOR checksum byte after the marker.
module debug_dump_sequencer #(
   parameter int NB_DATA     = 32,
   parameter int NB_REG      = 5,
   parameter int NB_ADDR     = 7,
   parameter int N_MEM_WORDS = 128,
   parameter int N_BITS      = 8
) (
   input logic i_clock,
   input logic i_reset,
   debug_dump_sequencer_if.master bus
);

   localparam int WB    = NB_DATA / N_BITS;
   localparam int BC_W  = $clog2(WB + 1);
   localparam int NREGS = 2 ** NB_REG;
   localparam int RI_W  = NB_REG + 1;
   localparam int MI_W  = NB_ADDR + 1;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_SEND     = 4'd1,
      S_WAIT_TX  = 4'd2,
      S_NEXT     = 4'd3,
      S_REG_RD   = 4'd4,
      S_REG_WAIT = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WAIT = 4'd7,
      S_END      = 4'd8
`ifdef DUMP_SEQ_CHECKSUM_EN
      , S_CKSUM  = 4'd9
`endif
   } state_t;

   // Phase records what the word just sent was, so NEXT knows what follows it.
   typedef enum logic [2:0] {
      P_PC    = 3'd0,
      P_CYC   = 3'd1,
      P_REG   = 3'd2,
      P_MADDR = 3'd3,
      P_MDATA = 3'd4,
      P_END   = 3'd5,
      P_CK    = 3'd6
   } phase_t;

   state_t             r_state;
   state_t             w_state_next;
   phase_t             r_phase;
   logic [NB_DATA-1:0] r_sr;
   logic [NB_DATA-1:0] r_hold;
   logic [NB_DATA-1:0] r_mword;
   logic [BC_W-1:0]    r_bc;
   logic [BC_W-1:0]    r_bc_last;
   logic [RI_W-1:0]    r_ri;
   logic [MI_W-1:0]    r_mi;
   logic               w_last_mem;
   logic               w_regs_done;
   logic               w_word_end;
   logic [N_BITS-1:0]  w_tx_byte;
   logic [N_BITS-1:0]  w_addr_byte;
`ifdef DUMP_SEQ_CHECKSUM_EN
   logic [N_BITS-1:0]  r_cksum;
`endif

   assign w_tx_byte   = r_sr[NB_DATA-1 -: N_BITS];
   assign w_addr_byte = {{(N_BITS-NB_ADDR){1'b0}}, r_mi[NB_ADDR-1:0]};
   assign w_last_mem  = (r_mi == MI_W'(N_MEM_WORDS - 1));
   assign w_regs_done = (r_ri == RI_W'(NREGS));
   assign w_word_end  = (r_bc == r_bc_last);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (bus.i_start) w_state_next = S_SEND;
         S_SEND:     w_state_next = S_WAIT_TX;
         S_WAIT_TX:  if (bus.i_tx_done) w_state_next = w_word_end ? S_NEXT : S_SEND;
         S_NEXT: begin
            case (r_phase)
               P_PC, P_MADDR: w_state_next = S_SEND;
               P_CYC:         w_state_next = S_REG_RD;
               P_REG:         w_state_next = w_regs_done ? S_MEM_RD : S_REG_RD;
               P_MDATA:       w_state_next = w_last_mem ? S_END : S_MEM_RD;
`ifdef DUMP_SEQ_CHECKSUM_EN
               P_END:         w_state_next = S_CKSUM;
`else
               P_END:         w_state_next = S_IDLE;
`endif
               default:       w_state_next = S_IDLE;
            endcase
         end
         S_REG_RD:   w_state_next = S_REG_WAIT;
         S_REG_WAIT: w_state_next = S_SEND;
         S_MEM_RD:   w_state_next = S_MEM_WAIT;
         S_MEM_WAIT: begin
            if (bus.i_mem_dirty) w_state_next = S_SEND;
            else if (w_last_mem) w_state_next = S_END;
            else                 w_state_next = S_MEM_RD;
         end
         S_END:      w_state_next = S_SEND;
`ifdef DUMP_SEQ_CHECKSUM_EN
         S_CKSUM:    w_state_next = S_SEND;
`endif
         default:    w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_phase   <= P_PC;
         r_sr      <= '0;
         r_hold    <= '0;
         r_mword   <= '0;
         r_bc      <= '0;
         r_bc_last <= '0;
         r_ri      <= '0;
         r_mi      <= '0;
`ifdef DUMP_SEQ_CHECKSUM_EN
         r_cksum   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_sr      <= bus.i_pc;
                  r_hold    <= bus.i_cycles;
                  r_bc      <= '0;
                  r_bc_last <= BC_W'(WB - 1);
                  r_ri      <= '0;
                  r_mi      <= '0;
                  r_phase   <= P_PC;
`ifdef DUMP_SEQ_CHECKSUM_EN
                  r_cksum   <= '0;
`endif
               end
            end
`ifdef DUMP_SEQ_CHECKSUM_EN
            S_SEND: r_cksum <= r_cksum ^ w_tx_byte;
`endif
            S_WAIT_TX: begin
               if (bus.i_tx_done) begin
                  r_sr <= r_sr << N_BITS;
                  r_bc <= w_word_end ? '0 : r_bc + BC_W'(1);
               end
            end
            S_NEXT: begin
               case (r_phase)
                  P_PC: begin
                     r_sr    <= r_hold;
                     r_phase <= P_CYC;
                  end
                  P_CYC:   r_phase <= P_REG;
                  P_MADDR: begin
                     r_sr      <= r_mword;
                     r_bc_last <= BC_W'(WB - 1);
                     r_phase   <= P_MDATA;
                  end
                  P_MDATA: if (!w_last_mem) r_mi <= r_mi + MI_W'(1);
                  default: ;
               endcase
            end
            S_REG_WAIT: begin
               r_sr      <= bus.i_reg_data;
               r_ri      <= r_ri + RI_W'(1);
               r_bc_last <= BC_W'(WB - 1);
               r_phase   <= P_REG;
            end
            S_MEM_WAIT: begin
               // A dirty word goes out as a single address byte, then its data word.
               if (bus.i_mem_dirty) begin
                  r_mword   <= bus.i_mem_data;
                  r_sr      <= {w_addr_byte, {(NB_DATA-N_BITS){1'b0}}};
                  r_bc_last <= '0;
                  r_phase   <= P_MADDR;
               end else if (!w_last_mem) begin
                  r_mi <= r_mi + MI_W'(1);
               end
            end
            S_END: begin
               r_sr      <= {{N_BITS{1'b1}}, {(NB_DATA-N_BITS){1'b0}}};
               r_bc_last <= '0;
               r_phase   <= P_END;
            end
`ifdef DUMP_SEQ_CHECKSUM_EN
            S_CKSUM: begin
               r_sr      <= {r_cksum, {(NB_DATA-N_BITS){1'b0}}};
               r_bc_last <= '0;
               r_phase   <= P_CK;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.o_tx_start  = (r_state == S_SEND);
   assign bus.o_tx_data   = w_tx_byte;
   assign bus.o_reg_rd    = (r_state == S_REG_RD);
   assign bus.o_reg_addr  = r_ri[NB_REG-1:0];
   assign bus.o_mem_rd    = (r_state == S_MEM_RD);
   assign bus.o_mem_addr  = r_mi[NB_ADDR-1:0];
   assign bus.o_busy      = (r_state != S_IDLE);
   assign bus.o_dbg_state = r_state;
`ifdef DUMP_SEQ_CHECKSUM_EN
   assign bus.o_done      = (r_state == S_NEXT) && (r_phase == P_CK);
`else
   assign bus.o_done      = (r_state == S_NEXT) && (r_phase == P_END);
`endif

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: byte-stream scoreboard built from the dump rules,
// register/memory responders and a uart_tx acknowledge model.
module tb_debug_dump_sequencer;
  localparam int NB_DATA     = 32;
  localparam int NB_REG      = 5;
  localparam int NB_ADDR     = 7;
  localparam int N_MEM_WORDS = 128;
  localparam int N_BITS      = 8;
`ifdef DUMP_SEQ_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_dump_sequencer_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR),
                            .N_BITS(N_BITS)) dif ();

  debug_dump_sequencer #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR),
                         .N_MEM_WORDS(N_MEM_WORDS), .N_BITS(N_BITS)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (dif)
  );

  logic tx_done_m = 1'b0;
  logic stray     = 1'b0;
  assign dif.i_tx_done = tx_done_m | stray;

  // reference data and scoreboard
  logic [NB_DATA-1:0] reg_m [2**NB_REG];
  logic [NB_DATA-1:0] mem_m [N_MEM_WORDS];
  bit                 dirty_m [N_MEM_WORDS];
  logic [NB_DATA-1:0] pc_m, cyc_m;
  logic [N_BITS-1:0]  exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int n_bytes = 0;
  int done_cnt = 0;
  int exp_len = 0;
  int stall_byte = -1;
  int ack_lo = 3;
  int ack_hi = 3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [NB_DATA-1:0] w);
    for (int b = NB_DATA/N_BITS - 1; b >= 0; b--) exp_q.push_back(w[b*N_BITS +: N_BITS]);
  endtask

  task automatic build_expected();
    logic [N_BITS-1:0] x;
    exp_q.delete();
    push_word(pc_m);
    push_word(cyc_m);
    for (int k = 0; k < 2**NB_REG; k++) push_word(reg_m[k]);
    for (int m = 0; m < N_MEM_WORDS; m++) begin
      if (dirty_m[m]) begin
        exp_q.push_back(N_BITS'(m));
        push_word(mem_m[m]);
      end
    end
    exp_q.push_back('1);
`ifdef DUMP_SEQ_CHECKSUM_EN
    x = '0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`else
    x = '0;
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, 64'({dif.o_reg_rd, dif.o_reg_addr, dif.o_mem_rd, dif.o_mem_addr, dif.o_tx_start,
                  dif.o_tx_data, dif.o_busy, dif.o_done}), 64'(0));
  endtask

  // register file and data memory: data valid the cycle after the read strobe
  initial begin : rd_model
    bit rp, mp;
    int ra, ma;
    rp = 0; mp = 0; ra = 0; ma = 0;
    forever begin
      @(posedge clk); #1;
      dif.i_reg_data = rp ? reg_m[ra] : NB_DATA'($urandom);
      if (mp) begin
        dif.i_mem_data  = mem_m[ma];
        dif.i_mem_dirty = dirty_m[ma];
      end else begin
        dif.i_mem_data  = NB_DATA'($urandom);
        dif.i_mem_dirty = 1'($urandom_range(1, 0));
      end
      rp = dif.o_reg_rd && !rst;
      ra = int'(dif.o_reg_addr);
      mp = dif.o_mem_rd && !rst;
      ma = int'(dif.o_mem_addr);
    end
  end

  // uart_tx model and byte scoreboard
  initial begin : tx_model
    int cd;
    logic [N_BITS-1:0] cur;
    cd = 0; cur = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cd = 0;
        tx_done_m = 1'b0;
      end else begin
        tx_done_m = 1'b0;
        if (dif.o_done) begin
          done_cnt++;
          chk("done_after_last_byte", 64'(exp_q.size()), 64'(0));
        end
        if (cd > 0) begin
          chk("tx_data_hold", 64'(dif.o_tx_data), 64'(cur));
          chk("tx_start_while_wait", 64'(dif.o_tx_start), 64'(0));
          cd--;
          if (cd == 0) tx_done_m = 1'b1;
        end else if (dif.o_tx_start) begin
          cur = dif.o_tx_data;
          chk("tx_byte_within_len", 64'(n_bytes < exp_len), 64'(1));
          if (exp_q.size() > 0) chk("tx_byte", 64'(cur), 64'(exp_q.pop_front()));
          n_bytes++;
          cd = (n_bytes - 1 == stall_byte) ? 203 : int'($urandom_range(ack_hi, ack_lo));
        end
      end
    end
  end

  // driver: one whole dump, with optional stall, repeated start or mid-dump reset
  task automatic run_dump(input int stall_at, input int restart_at, input int reset_at,
                          input int len_req);
    int cyc_cnt;
    bit re;
    build_expected();
    exp_len    = exp_q.size();
    n_bytes    = 0;
    done_cnt   = 0;
    stall_byte = stall_at;
    @(negedge clk);
    dif.i_pc     = pc_m;
    dif.i_cycles = cyc_m;
    dif.i_start  = 1'b1;
    @(negedge clk);
    dif.i_start  = 1'b0;
    dif.i_pc     = NB_DATA'($urandom);
    dif.i_cycles = NB_DATA'($urandom);
    chk("busy_after_start", 64'(dif.o_busy), 64'(1));
    re = 0;
    cyc_cnt = 0;
    while (done_cnt == 0 && cyc_cnt < 20000) begin
      @(negedge clk);
      cyc_cnt++;
      dif.i_start = 1'b0;
      if (!re && n_bytes == restart_at) begin
        re = 1;
        dif.i_start = 1'b1;
        dif.i_pc    = 32'hBAD0_BAD0;
      end
      if (n_bytes == reset_at) begin
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid_dump_async");
        @(posedge clk); #1;
        check_outputs_zero("reset_mid_dump_edge");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        stall_byte = -1;
        return;
      end
    end
    chk("dump_finished_in_budget", 64'(cyc_cnt < 20000), 64'(1));
    repeat (3) @(negedge clk);
    chk("byte_count", 64'(n_bytes), 64'(len_req));
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("busy_low_after", 64'(dif.o_busy), 64'(0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    stall_byte = -1;
  endtask

  task automatic load_scenario1();
    for (int k = 0; k < 2**NB_REG; k++) reg_m[k] = NB_DATA'(k);
    for (int m = 0; m < N_MEM_WORDS; m++) begin
      mem_m[m]   = NB_DATA'($urandom);
      dirty_m[m] = 0;
    end
    pc_m  = 32'h0000_0010;
    cyc_m = 32'h0000_002A;
  endtask

  initial begin : main
    int nd;
    dif.i_start  = 1'b0;
    dif.i_pc     = '0;
    dif.i_cycles = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst = 1'b0;

    // stray done while idle
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_stray_done", 64'({dif.o_busy, dif.o_tx_start}), 64'(0));
    end

    // basic dump with a long stall mid-word and a repeated start at byte 50
    load_scenario1();
    run_dump(21, 50, -1, 137 + CK);

    // two dirty words at the address extremes
    dirty_m[3]   = 1; mem_m[3]   = 32'hDEAD_BEEF;
    dirty_m[127] = 1; mem_m[127] = 32'h0102_0304;
    run_dump(-1, -1, -1, 147 + CK);

    // reset at byte 70, then a clean restart
    load_scenario1();
    run_dump(-1, -1, 70, 0);
    run_dump(-1, -1, -1, 137 + CK);

    // randomized contents and acknowledge latency
    ack_lo = 1;
    ack_hi = 5;
    for (int r = 0; r < 4; r++) begin
      nd = 0;
      for (int k = 0; k < 2**NB_REG; k++) reg_m[k] = NB_DATA'($urandom);
      for (int m = 0; m < N_MEM_WORDS; m++) begin
        mem_m[m]   = NB_DATA'($urandom);
        dirty_m[m] = ($urandom_range(7, 0) == 0);
        if (dirty_m[m]) nd++;
      end
      pc_m  = NB_DATA'($urandom);
      cyc_m = NB_DATA'($urandom);
      run_dump(-1, -1, -1, 137 + CK + 5*nd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Sequences the post-halt state dump from the pipeline to the UART transmitter.
- On a start pulse it sends, as a byte stream:
  - PC
  - cycle count
  - all 32 registers
  - every dirty data-memory word
  - an end marker
- It drives the register-file and data-memory debug read ports and owns the tx byte handshake.
- It sits between pipeline and uart_tx, under debug_unit control.

Parameters:
- NB_DATA, 32, width of PC, cycle count, register and memory words (multiple of N_BITS)
- NB_REG, 5, register address width; 2**NB_REG registers dumped
- NB_ADDR, 7, data-memory word address width; must be <= 7 so the address byte never equals 0xFF
- N_MEM_WORDS, 128, number of memory words scanned, <= 2**NB_ADDR
- N_BITS, 8, UART byte width

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1
- i_pc  in  NB_DATA  program counter; sampled on accepted i_start
- i_cycles  in  NB_DATA  cycle count; sampled on accepted i_start
- o_reg_rd  out  1  register debug read enable
- o_reg_addr  out  NB_REG  register debug address
- i_reg_data  in  NB_DATA  register data, valid 1 cycle after o_reg_rd
- o_mem_rd  out  1  memory debug read enable
- o_mem_addr  out  NB_ADDR  memory debug word address
- i_mem_data  in  NB_DATA  memory data, valid 1 cycle after o_mem_rd
- i_mem_dirty  in  1  dirty flag, valid together with i_mem_data
- o_tx_start  out  1  one-cycle pulse: o_tx_data valid, send it
- o_tx_data  out  N_BITS  byte to transmit
- i_tx_done  in  1  one-cycle pulse: byte fully sent
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse when the end marker is acknowledged

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, shift register and checksum 0.
- Reset is asynchronous. Asserting it mid-dump aborts immediately; no partial byte is resumed.
- States:
  - IDLE: on i_start, latch i_pc into shift reg SR, latch i_cycles into a hold reg, clear checksum, set o_busy, go to SEND.
  - SEND: byte counter bc counts 0..NB_DATA/N_BITS-1.
    - Each byte: drive o_tx_data = SR[MSB byte], pulse o_tx_start for 1 cycle, go to WAIT_TX.
  - WAIT_TX: hold o_tx_data stable until i_tx_done, then:
    - shift SR left by N_BITS and increment bc;
    - if more bytes remain, return to SEND; else go to NEXT.
    - The next o_tx_start comes no earlier than the cycle after i_tx_done.
  - NEXT: choose the next word by phase.
    - PC -> CYC (load hold reg into SR).
    - CYC or REG with regs left -> REG_RD.
    - last REG -> MEM_RD at address 0.
    - MEM address byte -> send its data word.
    - MEM data word -> next address, or END after N_MEM_WORDS-1.
  - REG_RD: o_reg_rd=1, o_reg_addr=ri for 1 cycle.
  - REG_WAIT: load i_reg_data into SR, increment ri, go to SEND.
  - MEM_RD: o_mem_rd=1, o_mem_addr=mi for 1 cycle.
  - MEM_WAIT:
    - if i_mem_dirty: send one address byte {0,mi}, then the 4 data bytes;
    - else increment mi and go to MEM_RD, or END if mi was the last address.
  - END: send 0xFF as a single byte, then (CKSUM if enabled), then pulse o_done, clear o_busy, go to IDLE.
- Word byte order: MSB first.
- Stream length: 4 + 4 + 4·2**NB_REG + 5·(dirty words) + 1 bytes.
- i_tx_done outside WAIT_TX is ignored.
- i_start during busy is ignored; no queuing.
- i_start on the same cycle as o_done is ignored.
- Counters ri and mi are sized to hold their terminal count and do not wrap before phase exit.

Optional Feature:
- Macro: DUMP_SEQ_CHECKSUM_EN
- Defined:
  - an 8-bit XOR checksum accumulates every byte transmitted, including 0xFF;
  - CKSUM state sends it as one extra byte after 0xFF;
  - o_done pulses after its i_tx_done.
- Undefined: no checksum register or state; o_done follows the 0xFF acknowledgement.

Test Plan:
- Reset, then i_start with i_pc=0x00000010, i_cycles=0x0000002A, reg[k]=k, no dirty memory, tx model acking 3 cycles after each start.
  - Expect bytes 00 00 00 10 00 00 00 2A, then 00000000..0000001F MSB first, then FF.
  - Expect 137 bytes total, o_done once, o_busy low afterwards.
- Memory words 3 and 127 dirty, holding 0xDEADBEEF and 0x01020304.
  - Expect 03 DE AD BE EF 7F 01 02 03 04 before FF; 147 bytes total.
- Hold i_tx_done low for 200 cycles mid-word, and pulse i_tx_done while in IDLE.
  - Expect o_tx_data stable and no extra o_tx_start during the stall.
  - Expect the stray IDLE done to have no effect.
- Pulse i_start again at byte 50.
  - Expect the stream unchanged, still 137 bytes.
- Assert i_reset at byte 70.
  - Expect all outputs 0 on the next edge.
  - A new i_start restarts from the PC bytes.
- With DUMP_SEQ_CHECKSUM_EN and the scenario-1 data.
  - Expect 138 bytes; the last byte is the XOR of the preceding 137 bytes.
